// File: rtl/rnic_exdes_pkg.sv
// Shared constants, FSM state type and header byte-order helper for the
// exdes RoCEv2 RX response generator.
package rnic_exdes_pkg;

    localparam logic [7:0]  RD_RSP_ONLY       = 8'h10;
    localparam logic [7:0]  RDMA_READ         = 8'h00;
    localparam logic [15:0] ETH_TYPE_IPv4     = 16'h0800;
    localparam logic [15:0] UDP_DST_PORT_ROCE = 16'd4791;
    localparam logic [15:0] UDP_SRC_PORT      = 16'hE348;
    localparam logic [7:0]  PROTOCOL_UDP      = 8'h11;
    localparam int unsigned HDR_BYTES         = 58;
    localparam int unsigned ICRC_BYTES        = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HDR,
        ST_PAYLOAD
    } rsp_state_e;

    // Header is assembled in wire order (byte 0 at MSB); the stream wants byte 0 at LSB.
    function automatic logic [HDR_BYTES*8-1:0] hdr_byte_reorder(input logic [HDR_BYTES*8-1:0] be);
        logic [HDR_BYTES*8-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < HDR_BYTES; i++) begin
            r[8*i +: 8] = be[8*(HDR_BYTES-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rnic_exdes_rx_rsp_gen_if.sv
// Request and AXI-Stream signals of the RX response generator.
interface rnic_exdes_rx_rsp_gen_if;

    logic         req_valid;
    logic         req_ready;
    logic [23:0]  req_psn;
    logic [23:0]  req_dqp;
    logic [15:0]  req_len;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;

    modport master (
        input  req_valid, req_psn, req_dqp, req_len, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output req_valid, req_psn, req_dqp, req_len, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/rnic_exdes_ipv4_csum.sv
// IPv4 header checksum: ones'-complement of the ones'-complement sum of the
// ten 16-bit words of a 20-byte header (wire order, byte 0 at MSB).
module rnic_exdes_ipv4_csum (
    input  logic [159:0] ip_hdr,
    output logic [15:0]  csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [16:0] fold2;

    // Sum the words, then fold carries back twice (second fold absorbs any new carry).
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            sum = sum + {4'd0, ip_hdr[16*i +: 16]};
        end
        fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2 = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
        csum  = ~fold2[15:0];
    end

endmodule

// File: rtl/rnic_exdes_rx_rsp_gen.sv
// RoCEv2 RDMA Read Response Only packet generator feeding the ERNIC RX stream.
// Optional: RX_IPV4_CSUM_EN computes the IPv4 header checksum in an extra CALC cycle.
module rnic_exdes_rx_rsp_gen
    import rnic_exdes_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD  = 256,
    parameter logic [47:0] SRC_MAC      = 48'h0A0B0C0D0E0F,
    parameter logic [47:0] DST_MAC      = 48'h001122334455,
    parameter logic [31:0] SRC_IP       = 32'hC0A80102,
    parameter logic [31:0] DST_IP       = 32'hC0A80101,
    parameter logic [7:0]  PAYLOAD_BYTE = 8'hFF
) (
    input  logic                           core_clk,
    input  logic                           core_aresetn,
    rnic_exdes_rx_rsp_gen_if.master        bus,
    output logic                           req_len_err,
    output logic [15:0]                    pkt_sent_cnt
);

`ifdef RX_IPV4_CSUM_EN
    localparam rsp_state_e ST_AFTER_ACCEPT = ST_CALC;
`else
    localparam rsp_state_e ST_AFTER_ACCEPT = ST_HDR;
`endif

    rsp_state_e state_q, state_d;
    logic [23:0] psn_q, dqp_q;
    logic [15:0] len_q, beat_q, last_beat_q, cnt_q;
    logic        err_q;

    logic        req_ready_w, accept, len_bad, tvalid, handshake, beat_is_last;
    logic [15:0] req_total, total, csum, g;
    logic [5:0]  rem;
    logic [63:0] keep_last;
    logic [159:0] ip_hdr_zero;
    logic [HDR_BYTES*8-1:0] hdr_be, hdr;
    logic [511:0] tdata_w;

    assign req_ready_w  = (state_q == ST_IDLE) && core_aresetn;
    assign accept       = bus.req_valid && req_ready_w;
    assign len_bad      = (bus.req_len > 16'(MAX_PAYLOAD)) || (bus.req_len[1:0] != 2'b00);
    assign req_total    = 16'(HDR_BYTES + ICRC_BYTES) + bus.req_len;
    assign total        = 16'(HDR_BYTES + ICRC_BYTES) + len_q;
    assign handshake    = tvalid && bus.m_axis_tready;
    assign beat_is_last = (beat_q == last_beat_q);

    // State register.
    always_ff @(posedge core_clk) begin
        if (!core_aresetn) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // Next-state and beat-valid decode.
    always_comb begin
        state_d = state_q;
        tvalid  = 1'b0;
        case (state_q)
            ST_IDLE:    if (accept && !len_bad) state_d = ST_AFTER_ACCEPT;
            ST_CALC:    state_d = ST_HDR;
            ST_HDR, ST_PAYLOAD: begin
                tvalid = 1'b1;
                if (bus.m_axis_tready) state_d = beat_is_last ? ST_IDLE : ST_PAYLOAD;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request capture, beat counter, error pulse and packet counter.
    always_ff @(posedge core_clk) begin
        if (!core_aresetn) begin
            psn_q       <= '0;
            dqp_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept && len_bad;
            if (accept && !len_bad) begin
                psn_q       <= bus.req_psn;
                dqp_q       <= bus.req_dqp;
                len_q       <= bus.req_len;
                beat_q      <= '0;
                last_beat_q <= (req_total - 16'd1) >> 6;
            end else if (handshake && !beat_is_last) begin
                beat_q <= beat_q + 16'd1;
            end
            if (handshake && beat_is_last) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ip_hdr_zero = {8'h45, 8'h00, 16'd48 + len_q, 16'h0000, 16'h0000,
                          8'h40, PROTOCOL_UDP, 16'h0000, SRC_IP, DST_IP};

`ifdef RX_IPV4_CSUM_EN
    logic [15:0] csum_calc, csum_q;

    rnic_exdes_ipv4_csum u_csum (
        .ip_hdr (ip_hdr_zero),
        .csum   (csum_calc)
    );

    // Latch the checksum during CALC so the header beat stays stable under stalls.
    always_ff @(posedge core_clk) begin
        if (!core_aresetn)          csum_q <= '0;
        else if (state_q == ST_CALC) csum_q <= csum_calc;
    end
    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    assign hdr_be = {DST_MAC, SRC_MAC, ETH_TYPE_IPv4,
                     ip_hdr_zero | {80'd0, csum, 64'd0},
                     UDP_SRC_PORT, UDP_DST_PORT_ROCE, 16'd28 + len_q, 16'h0000,
                     RD_RSP_ONLY, 8'h00, 16'hFFFF, 8'h00, dqp_q, 8'h00, psn_q,
                     32'h0000_0000};
    assign hdr = hdr_byte_reorder(hdr_be);

    // Beat assembly: payload fill by absolute byte index, header overlays beat 0;
    // ICRC and bytes past the packet end stay zero.
    always_comb begin
        tdata_w = '0;
        g       = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            g = (beat_q << 6) + 16'(k);
            if (g < 16'(HDR_BYTES) + len_q) tdata_w[8*k +: 8] = PAYLOAD_BYTE;
        end
        if (beat_q == 16'd0) tdata_w[HDR_BYTES*8-1:0] = hdr;
    end

    assign rem       = total[5:0];
    assign keep_last = (rem == 6'd0) ? '1 : ((64'd1 << rem) - 64'd1);

    assign bus.req_ready     = req_ready_w;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tvalid ? tdata_w : '0;
    assign bus.m_axis_tkeep  = !tvalid ? '0 : (beat_is_last ? keep_last : '1);
    assign bus.m_axis_tlast  = tvalid && beat_is_last;
    assign req_len_err       = err_q;
    assign pkt_sent_cnt      = cnt_q;

endmodule

// File: tb/tb_rnic_exdes_rx_rsp_gen.sv
// Self-checking bench for rnic_exdes_rx_rsp_gen: directed cases plus random
// requests against a byte-list packet model.
module tb_rnic_exdes_rx_rsp_gen;
    import rnic_exdes_pkg::*;

    localparam int unsigned MAXP  = 256;
    localparam logic [47:0] SMAC  = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] DMAC  = 48'h001122334455;
    localparam logic [31:0] SIP   = 32'hC0A80102;
    localparam logic [31:0] DIP   = 32'hC0A80101;
    localparam logic [7:0]  PBYTE = 8'hFF;
`ifdef RX_IPV4_CSUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        core_clk;
    logic        core_aresetn;
    logic        req_len_err;
    logic [15:0] pkt_sent_cnt;

    rnic_exdes_rx_rsp_gen_if bus();

    rnic_exdes_rx_rsp_gen #(
        .MAX_PAYLOAD  (MAXP),
        .SRC_MAC      (SMAC),
        .DST_MAC      (DMAC),
        .SRC_IP       (SIP),
        .DST_IP       (DIP),
        .PAYLOAD_BYTE (PBYTE)
    ) dut (
        .core_clk     (core_clk),
        .core_aresetn (core_aresetn),
        .bus          (bus.master),
        .req_len_err  (req_len_err),
        .pkt_sent_cnt (pkt_sent_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0]  exp_cnt;
    logic [7:0]   exp_q[$];
    logic [511:0] first_beat;
    logic [63:0]  last_keep;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endfunction

    // Reference packet as a plain list of wire bytes.
    function automatic void build(input int len, input logic [23:0] psn, input logic [23:0] dqp);
        exp_q.delete();
        put(DMAC, 6); put(SMAC, 6); put(64'h0800, 2);
        put(64'h45, 1); put(0, 1); put(64'(48 + len), 2); put(0, 4);
        put(64'h40, 1); put(64'h11, 1); put(0, 2); put(SIP, 4); put(DIP, 4);
        put(64'hE348, 2); put(64'd4791, 2); put(64'(28 + len), 2); put(0, 2);
        put(64'h10, 1); put(0, 1); put(64'hFFFF, 2); put(0, 1); put(dqp, 3); put(0, 1); put(psn, 3);
        put(0, 4);
        for (int i = 0; i < len; i++) exp_q.push_back(PBYTE);
        put(0, 4);
`ifdef RX_IPV4_CSUM_EN
        begin
            int unsigned s;
            logic [15:0] c;
            s = 0;
            for (int i = 14; i < 34; i += 2) s += {16'd0, exp_q[i], exp_q[i+1]};
            while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
            c = ~s[15:0];
            exp_q[24] = c[15:8];
            exp_q[25] = c[7:0];
        end
`endif
    endfunction

    function automatic logic [511:0] exp_data(input int b);
        logic [511:0] d;
        d = '0;
        for (int k = 0; k < 64; k++) if (b*64 + k < exp_q.size()) d[8*k +: 8] = exp_q[b*64 + k];
        return d;
    endfunction

    function automatic logic [63:0] exp_keep(input int b);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 64; k++) if (b*64 + k < exp_q.size()) m[k] = 1'b1;
        return m;
    endfunction

    task automatic send_req(input logic [23:0] psn, input logic [23:0] dqp, input logic [15:0] len);
        int w;
        w = 0;
        while (!bus.req_ready && w < 50) begin @(posedge core_clk); #1; w++; end
        check("req_ready_pre", 512'(bus.req_ready), 512'(1));
        bus.req_valid = 1'b1; bus.req_psn = psn; bus.req_dqp = dqp; bus.req_len = len;
        @(posedge core_clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // mode 0: tready high, 1: toggling, 2: random
    task automatic collect(input int mode);
        int lat, beat, cyc, nb;
        bit done, stalled, tr;
        logic [511:0] hd;
        logic [63:0]  hk;
        logic         hl;
        nb = (exp_q.size() + 63) / 64;
        lat = 1;
        while (!bus.m_axis_tvalid && lat < 10) begin @(posedge core_clk); #1; lat++; end
        check("latency", 512'(lat), 512'(LAT));
        beat = 0; cyc = 0; done = 0; stalled = 0;
        hd = '0; hk = '0; hl = 1'b0;
        while (!done && cyc < 2000) begin
            tr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            bus.m_axis_tready = tr;
            if (stalled) begin
                check("tvalid_held", 512'(bus.m_axis_tvalid), 512'(1));
                check("tdata_stable", bus.m_axis_tdata, hd);
                check("tkeep_stable", 512'(bus.m_axis_tkeep), 512'(hk));
                check("tlast_stable", 512'(bus.m_axis_tlast), 512'(hl));
            end
            if (bus.m_axis_tvalid) begin
                if (tr) begin
                    check("tdata", bus.m_axis_tdata, exp_data(beat));
                    check("tkeep", 512'(bus.m_axis_tkeep), 512'(exp_keep(beat)));
                    check("tlast", 512'(bus.m_axis_tlast), 512'(beat == nb - 1));
                    if (beat == 0) first_beat = bus.m_axis_tdata;
                    last_keep = bus.m_axis_tkeep;
                    if (bus.m_axis_tlast) done = 1;
                    beat++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = bus.m_axis_tdata; hk = bus.m_axis_tkeep; hl = bus.m_axis_tlast;
                end
            end
            @(posedge core_clk); #1;
            cyc++;
        end
        bus.m_axis_tready = 1'b0;
        check("pkt_done", 512'(done), 512'(1));
        check("beats", 512'(beat), 512'(nb));
        exp_cnt = exp_cnt + 16'd1;
        check("pkt_sent_cnt", 512'(pkt_sent_cnt), 512'(exp_cnt));
        check("req_ready_after", 512'(bus.req_ready), 512'(1));
        check("idle_gap_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
        check("csum_bytes", 512'(first_beat[24*8 +: 16]), 512'({exp_q[25], exp_q[24]}));
    endtask

    task automatic bad_req(input logic [15:0] len);
        send_req(24'h0, 24'h0, len);
        check("len_err_pulse", 512'(req_len_err), 512'(1));
        check("len_err_no_valid", 512'(bus.m_axis_tvalid), 512'(0));
        @(posedge core_clk); #1;
        check("len_err_clear", 512'(req_len_err), 512'(0));
        check("len_err_no_valid2", 512'(bus.m_axis_tvalid), 512'(0));
        check("len_err_cnt", 512'(pkt_sent_cnt), 512'(exp_cnt));
        check("len_err_ready", 512'(bus.req_ready), 512'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "global time limit");
    end

    initial begin
        int hs, w, len;
        logic [23:0] psn, dqp;
        exp_cnt = '0;
        core_aresetn = 1'b0;
        bus.req_valid = 1'b0; bus.req_psn = '0; bus.req_dqp = '0; bus.req_len = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        check("rst_req_ready", 512'(bus.req_ready), 512'(0));
        check("rst_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
        check("rst_tdata", bus.m_axis_tdata, 512'(0));
        check("rst_tkeep", 512'(bus.m_axis_tkeep), 512'(0));
        check("rst_tlast", 512'(bus.m_axis_tlast), 512'(0));
        check("rst_len_err", 512'(req_len_err), 512'(0));
        check("rst_cnt", 512'(pkt_sent_cnt), 512'(0));
        core_aresetn = 1'b1;
        #1;
        check("post_rst_ready", 512'(bus.req_ready), 512'(1));
        @(posedge core_clk); #1;

        // Full-size packet
        build(256, 24'h000123, 24'h000002);
        send_req(24'h000123, 24'h000002, 16'd256);
        collect(0);
        check("len256_last_keep", 512'(last_keep), 512'(64'h3FFF_FFFF_FFFF_FFFF));
        check("len256_b16", 512'(first_beat[16*8 +: 8]), 512'(8'h01));
        check("len256_b17", 512'(first_beat[17*8 +: 8]), 512'(8'h30));
        check("len256_b38", 512'(first_beat[38*8 +: 8]), 512'(8'h01));
        check("len256_b39", 512'(first_beat[39*8 +: 8]), 512'(8'h1C));
        check("len256_b42", 512'(first_beat[42*8 +: 8]), 512'(8'h10));
        check("len256_cnt1", 512'(pkt_sent_cnt), 512'(1));

        // Zero-length payload
        build(0, 24'h00ABCD, 24'h000011);
        send_req(24'h00ABCD, 24'h000011, 16'd0);
        collect(0);
        check("len0_keep", 512'(last_keep), 512'(64'h3FFF_FFFF_FFFF_FFFF));
        check("len0_iplen", 512'(first_beat[16*8 +: 16]), 512'(16'h3000));

        // Rejected lengths
        bad_req(16'd258);
        bad_req(16'd260);

        // Stalls every other cycle
        build(64, 24'h0F0F0F, 24'h000007);
        send_req(24'h0F0F0F, 24'h000007, 16'd64);
        collect(1);
        check("len64_keep", 512'(last_keep), 512'(64'h3FFF_FFFF_FFFF_FFFF));

        // Reset in the middle of a packet
        build(256, 24'h000555, 24'h000003);
        send_req(24'h000555, 24'h000003, 16'd256);
        bus.m_axis_tready = 1'b1;
        hs = 0; w = 0;
        while (hs < 2 && w < 50) begin
            if (bus.m_axis_tvalid) hs++;
            @(posedge core_clk); #1;
            w++;
        end
        check("mid_beat2_valid", 512'(bus.m_axis_tvalid), 512'(1));
        check("mid_beat2_data", bus.m_axis_tdata, exp_data(2));
        core_aresetn = 1'b0;
        @(posedge core_clk); #1;
        check("mid_rst_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
        check("mid_rst_tlast", 512'(bus.m_axis_tlast), 512'(0));
        check("mid_rst_cnt", 512'(pkt_sent_cnt), 512'(0));
        check("mid_rst_ready", 512'(bus.req_ready), 512'(0));
        core_aresetn = 1'b1;
        bus.m_axis_tready = 1'b0;
        exp_cnt = '0;
        @(posedge core_clk); #1;
        check("mid_rst_ready_after", 512'(bus.req_ready), 512'(1));
        build(128, 24'h000556, 24'h000003);
        send_req(24'h000556, 24'h000003, 16'd128);
        collect(0);

        // Random requests, legal and illegal
        for (int it = 0; it < 30; it++) begin
            len = int'($urandom_range(0, 300));
            psn = 24'($urandom);
            dqp = 24'($urandom);
            if (len > int'(MAXP) || (len % 4) != 0) begin
                bad_req(16'(len));
            end else begin
                build(len, psn, dqp);
                send_req(psn, dqp, 16'(len));
                collect(int'($urandom_range(0, 2)));
            end
            repeat ($urandom_range(0, 2)) @(posedge core_clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
